// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types, constants and helpers for gray_conv_arbiter.
// Also carries the clb build defines: DATA_WIDTH, GRAY_ARB_NUM_REQ and the
// optional GRAY_ARB_STEP_CHECK_EN (left undefined here, so the default build
// has no Gray-step checking; define it on the command line or here to enable).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef GRAY_ARB_NUM_REQ
`define GRAY_ARB_NUM_REQ 4
`endif

package gray_conv_arbiter_pkg;

  localparam int DATA_W      = `DATA_WIDTH;
  localparam int DEF_NUM_REQ = `GRAY_ARB_NUM_REQ;

  // Output slot occupancy; FULL means out_valid is high.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Number of set bits; a legal Gray step flips at most one bit.
  function automatic int unsigned gray_popcount(input logic [DATA_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < DATA_W; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at and above its position.
module gray_to_bin
  import gray_conv_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] gray,
  output logic [DATA_W-1:0] binary
);

  // Running XOR from the MSB downward.
  always_comb begin
    binary = '0;
    binary[DATA_W-1] = gray[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) begin
      binary[i] = binary[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter. Searches upward from ptr,
// wrapping modulo N, and grants the first asserted request when en is high.
// The rotate pointer itself is owned by the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  // Rotating priority search; first hit wins, later hits are ignored.
  always_comb begin
    int  j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  assign grant_any = |grant;

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: NUM_REQ requesters share one gray_to_bin converter via a
// round-robin arbiter; the result sits in one registered, id-tagged output
// slot. Optional feature macro: GRAY_ARB_STEP_CHECK_EN (sticky per-requester
// flag when consecutive accepted Gray words differ in more than one bit).
//
// Handshakes: a side transfers on a rising clk edge where its valid and ready
// are both high. Requesters hold req_valid/req_gray stable until transfer and
// never derive req_valid from req_ready. out_valid/out_binary/out_id stay
// stable while out_valid is high and out_ready is low.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_gray,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_binary,
  output logic [ID_W-1:0]             out_id,
  output logic [NUM_REQ-1:0]          step_err
);

  slot_state_t         slot_state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     ptr_next;
  logic                slot_free;
  logic                arb_en;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic                xfer;
  logic [DATA_W-1:0]   sel_gray;
  logic [DATA_W-1:0]   conv_bin;

  // The slot can take a new word when empty or when it is being drained now.
  assign slot_free = (slot_state == SLOT_EMPTY) || out_ready;
  // No grants while reset is held.
  assign arb_en    = slot_free && rst_n;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req       (req_valid),
    .en        (arb_en),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & req_ready);
  assign out_valid = (slot_state == SLOT_FULL);

  // Grant-indexed mux feeding the single shared converter.
  always_comb begin
    sel_gray = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_gray = req_gray[i*DATA_W +: DATA_W];
    end
  end

  gray_to_bin u_g2b (
    .gray   (sel_gray),
    .binary (conv_bin)
  );

  // Pointer moves to the requester just after the winner, wrapping at NUM_REQ.
  always_comb begin
    ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  // Output slot FSM: load on transfer (even while draining), else empty on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_state <= SLOT_EMPTY;
      out_binary <= '0;
      out_id     <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      slot_state <= SLOT_FULL;
      out_binary <= conv_bin;
      out_id     <= grant_idx;
      rr_ptr     <= ptr_next;
    end else if (slot_state == SLOT_FULL && out_ready) begin
      slot_state <= SLOT_EMPTY;
    end
  end

`ifdef GRAY_ARB_STEP_CHECK_EN
  logic [DATA_W-1:0]  last_gray [NUM_REQ];
  logic [NUM_REQ-1:0] seen;
  logic [NUM_REQ-1:0] err_q;

  // Remember each requester's last accepted word; flag multi-bit steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        last_gray[i] <= '0;
      end
      seen  <= '0;
      err_q <= '0;
    end else if (xfer) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          if (seen[i] && (gray_popcount(sel_gray ^ last_gray[i]) > 1)) begin
            err_q[i] <= 1'b1;
          end
          last_gray[i] <= sel_gray;
          seen[i]      <= 1'b1;
        end
      end
    end
  end

  assign step_err = err_q;
`else
  assign step_err = '0;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter with NUM_REQ=4 and 8-bit data.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_gray_conv_arbiter;

  localparam int N = 4;
  localparam int W = 8;

`ifdef GRAY_ARB_STEP_CHECK_EN
  localparam logic [N-1:0] ERR1 = 4'b0010;
`else
  localparam logic [N-1:0] ERR1 = 4'b0000;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_gray;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_binary;
  logic [1:0]       out_id;
  logic [N-1:0]     step_err;

  int total = 0;
  int bad   = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  gray_conv_arbiter #(
    .NUM_REQ (N),
    .ID_W    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_gray   (req_gray),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_binary (out_binary),
    .out_id     (out_id),
    .step_err   (step_err)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_gray(input int i, input logic [W-1:0] v);
    req_gray[i*W +: W] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] step_seq [4];
  logic [W-1:0] step_bin [4];

  initial begin
    step_seq = '{8'h00, 8'h01, 8'h01, 8'h07};
    step_bin = '{8'h00, 8'h01, 8'h01, 8'h05};

    // Reset state, with requests pending: nothing may be granted.
    rst_n     = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b1;
    req_gray  = '0;
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_bin",   32'(out_binary), 0);
    chk("rst_id",    32'(out_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_err",   32'(step_err), 0);

    // Round robin: gray 00,01,03,02 -> binary 0,1,2,3.
    req_valid = 4'h0;
    set_gray(0, 8'h00);
    set_gray(1, 8'h01);
    set_gray(2, 8'h03);
    set_gray(3, 8'h02);
    rst_n = 1'b1;
    settle();
    req_valid = 4'hF;
    settle();
    chk("rr_ready0", 32'(req_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_id",    32'(out_id), 32'(k % 4));
      chk("rr_bin",   32'(out_binary), 32'(k % 4));
    end
    req_valid = 4'h0;
    tick();
    chk("rr_drain_valid", 32'(out_valid), 0);

    // Single request from requester 2: gray 06 -> binary 04.
    set_gray(2, 8'h06);
    req_valid = 4'b0100;
    settle();
    chk("one_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'h0;
    chk("one_valid", 32'(out_valid), 1);
    chk("one_bin",   32'(out_binary), 32'h04);
    chk("one_id",    32'(out_id), 2);
    tick();
    chk("one_empty", 32'(out_valid), 0);
    chk("one_hold_bin", 32'(out_binary), 32'h04);
    chk("one_hold_id",  32'(out_id), 2);

    // Backpressure: gray 0F -> 0A held while out_ready is low.
    set_gray(0, 8'h0F);
    req_valid = 4'b0001;
    out_ready = 1'b0;
    settle();
    chk("bp_ready_empty", 32'(req_ready), 32'b0001);
    tick();
    set_gray(1, 8'h05);
    req_valid = 4'b0010;
    settle();
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_bin",   32'(out_binary), 32'h0A);
      chk("bp_id",    32'(out_id), 0);
      tick();
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'h0;
    chk("bp_reload_valid", 32'(out_valid), 1);
    chk("bp_reload_bin",   32'(out_binary), 32'h06);
    chk("bp_reload_id",    32'(out_id), 1);
    tick();
    chk("bp_empty", 32'(out_valid), 0);

    // Reset mid-stream: gray FF -> AA from requester 3, then async reset.
    set_gray(3, 8'hFF);
    req_valid = 4'b1000;
    settle();
    tick();
    chk("mid_valid", 32'(out_valid), 1);
    chk("mid_bin",   32'(out_binary), 32'hAA);
    chk("mid_id",    32'(out_id), 3);
    req_valid = 4'h0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_bin",   32'(out_binary), 0);
    chk("arst_id",    32'(out_id), 0);
    req_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    chk("arst_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    settle();
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_id",    32'(out_id), 0);
    chk("post_rst_bin",   32'(out_binary), 32'h0A);
    req_valid = 4'h0;
    tick();

    // Gray step check on requester 1: 00,01,01,07 (last step flips two bits).
    for (int k = 0; k < 4; k++) begin
      set_gray(1, step_seq[k]);
      req_valid = 4'b0010;
      settle();
      tick();
      chk("step_bin", 32'(out_binary), 32'(step_bin[k]));
      chk("step_err", 32'(step_err), (k == 3) ? 32'(ERR1) : 32'h0);
    end
    req_valid = 4'h0;
    tick();
    tick();
    chk("step_sticky", 32'(step_err), 32'(ERR1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Shares one Gray-to-binary converter among `NUM_REQ` requesters, for example FIFO pointer or counter sources in the CLB test designs. A round-robin arbiter grants one requester per cycle. The grant feeds the shared `gray_to_bin` converter. The result lands in a single registered output slot, tagged with the requester index, behind a valid/ready handshake.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `out_id`, minimum 1.
- Data width is `` `DATA_WIDTH `` from `clb_defines.v`; it is not a parameter.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high (one-hot or zero).
- `req_gray`  in  NUM_REQ*`DATA_WIDTH`  packed Gray words; requester i occupies bits [i*W +: W].
- `out_valid`  out  1  output slot holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_binary`  out  `DATA_WIDTH`  converted value.
- `out_id`  out  ID_W  index of the requester that produced `out_binary`.
- `step_err`  out  NUM_REQ  sticky per-requester Gray-step error (see Configuration).

## Operation
- Output slot has two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `slot_free` = EMPTY, or (FULL and `out_ready`).
- Arbitration is combinational from `req_valid`, `slot_free` and the rotate pointer `rr_ptr`:
  - If `slot_free` is high, grant the first valid requester searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[g]`=1 only for the granted requester `g`.
  - If `slot_free` is low, `req_ready` is all zero.
- Transfer occurs when `req_valid[i] & req_ready[i]`. On transfer:
  - Slot loads `gray_to_bin(req_gray[g])` and `out_id`=g, and enters FULL.
  - `rr_ptr` becomes (g+1) mod NUM_REQ.
- With no transfer, `rr_ptr` holds.
- FULL with `out_ready` and no transfer: slot goes to EMPTY; `out_binary` and `out_id` hold their last values.
- FULL, `out_ready`=0: `out_valid`, `out_binary` and `out_id` are stable. No grant is issued.
- Simultaneous drain and grant in the same cycle: the slot is reloaded and stays FULL, so throughput is one result per cycle.
- Requesters must not make `req_valid` depend on `req_ready`. Once asserted, `req_valid` and `req_gray` hold until transfer.
- Reset values: `out_valid`=0, `out_binary`=0, `out_id`=0, `rr_ptr`=0, `step_err`=0. `req_ready` is 0 while `rst_n` is low.
- Reset asserted mid-transfer discards the slot contents immediately. The next grant after release starts the search from requester 0.

## Timing
- Request accepted in cycle N gives `out_valid`=1 with its data in cycle N+1.
- Combinational paths:
  - `req_valid` → `req_ready`
  - `out_ready` → `req_ready`
- There is no combinational path from request inputs to outputs other than `req_ready`.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 transfers before its grant.

## Configuration
- `GRAY_ARB_STEP_CHECK_EN` defined:
  - Per requester, store the last accepted Gray word and a seen flag.
  - The first accepted word after reset is never checked.
  - On each later transfer, `step_err[i]` sets when popcount(new ^ last) > 1. Equal words (0 bits differ) are legal.
  - `step_err` bits are sticky until reset and assert the cycle after the offending transfer.
- `GRAY_ARB_STEP_CHECK_EN` undefined:
  - No storage is built.
  - `step_err` is tied to 0.

## Structure
- `clb_defines.v` holds `` `DATA_WIDTH `` and a new `` `GRAY_ARB_NUM_REQ `` default that the top level uses for `NUM_REQ`.
- The macro `GRAY_ARB_STEP_CHECK_EN` is set in the same defines file.
- Sub-module `rr_arbiter`: inputs are req vector, enable (`slot_free`) and `rr_ptr`; output is one-hot grant plus encoded index. It is purely combinational; `rr_ptr` lives in the parent.
- Conversion instantiates the shared `gray_to_bin` once, driven by a grant-indexed mux of `req_gray`.

## Test plan
All scenarios use NUM_REQ=4 and `DATA_WIDTH`=8.
- Single request: req 2 sends gray 0x06 with `out_ready`=1 → one cycle later `out_valid`=1, `out_binary`=0x04, `out_id`=2. `req_ready` was 4'b0100 in the accept cycle.
- Round robin: all four `req_valid` held high with `out_ready`=1 → `out_id` sequence 0,1,2,3,0, one result per cycle.
- Backpressure: slot FULL with 0x0A (from gray 0x0F) and `out_ready` low for 5 cycles → outputs stable, `req_ready`=0. First `out_ready` cycle → drain and next grant in the same cycle, `out_valid` stays 1.
- Reset mid-stream: drop `rst_n` while FULL → `out_valid`, `out_binary`, `out_id` go to 0 asynchronously. After release, with all requesters valid, the first grant is requester 0.
- Step check (macro defined): req 1 sends 0x00, 0x01, 0x01, 0x07 → `step_err[1]` rises one cycle after the 0x07 transfer and stays high. Rebuilt without the macro → `step_err` stays 0.
